// File: rtl/rv_pkg.sv
// Shared constants and the fetch slot record used by the fetch stage.
// No logic; imported by fetch_queue and fetch_unit.
package rv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetch slots: reserve at tail, fill oldest pending, pop head, flush.
// Latency: a fill aimed at the head is visible on head_* in the same cycle; no backpressure, caller checks count.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     rsv_en,
    input  logic [31:0]              rsv_pc,
    input  logic                     fill_en,
    input  logic [31:0]              fill_instr,
    input  logic                     pop_en,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pend,
    output logic                     head_ready,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    fetch_slot_t slots [DEPTH];
    logic [AW:0] head_q, tail_q, fill_q;
    logic        fill_hits_head;

    assign count = tail_q - head_q;
    assign pend  = tail_q - fill_q;

    // A pending head being filled this cycle is forwarded so the consumer sees it without a bubble.
    assign fill_hits_head = fill_en && (fill_q == head_q);
    assign head_pc        = slots[head_q[AW-1:0]].pc;
    assign head_instr     = fill_hits_head ? fill_instr : slots[head_q[AW-1:0]].instr;
    assign head_ready     = (count != '0) && (slots[head_q[AW-1:0]].filled || fill_hits_head);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else begin
            if (rsv_en) begin
                slots[tail_q[AW-1:0]].pc     <= rsv_pc;
                slots[tail_q[AW-1:0]].filled <= 1'b0;
                tail_q                       <= tail_q + PTR_ONE;
            end
            if (fill_en) begin
                slots[fill_q[AW-1:0]].instr  <= fill_instr;
                slots[fill_q[AW-1:0]].filled <= 1'b1;
                fill_q                       <= fill_q + PTR_ONE;
            end
            if (pop_en) begin
                head_q <= head_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches, buffers in-order responses, hands {instr, pc} to decode.
// Latency: request to inst_valid_o is 2 cycles with 1-cycle memory; requests stop when slots are exhausted, decode stalls hold the head.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(2 * DEPTH + 1) + 1;
    localparam logic [DW-1:0] SLOTS = DW'(DEPTH);
    localparam logic [DW-1:0] LIMIT = DW'(2 * DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [DW-1:0] drop_q, drop_d, cnt_d;
    logic          inst_valid_q;
    logic [31:0]   inst_q, inst_pc_q;

    logic [CW-1:0] q_count, q_pend;
    logic          q_head_ready;
    logic [31:0]   q_head_pc, q_head_instr;
    logic          req_acc, rsv_en, rsp_keep, out_free, pop_en;

    assign imem_req_valid_o = (state_q == ST_REQ);
    assign imem_req_addr_o  = pc_q;

    assign req_acc  = imem_req_valid_o && imem_req_ready_i;
    assign rsv_en   = req_acc && !redirect_valid_i;
    assign rsp_keep = imem_rsp_valid_i && (drop_q == '0) && !redirect_valid_i;
    assign out_free = !inst_valid_q || inst_ready_i;
    assign pop_en   = out_free && q_head_ready && !redirect_valid_i;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid_i),
        .rsv_en     (rsv_en),
        .rsv_pc     (pc_q),
        .fill_en    (rsp_keep),
        .fill_instr (imem_rsp_data_i),
        .pop_en     (pop_en),
        .count      (q_count),
        .pend       (q_pend),
        .head_ready (q_head_ready),
        .head_pc    (q_head_pc),
        .head_instr (q_head_instr)
    );

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        cnt_d  = DW'(q_count);
        if (redirect_valid_i) begin
            pc_d   = redirect_pc_i & 32'hFFFF_FFFC;
            cnt_d  = '0;
            // Everything still owed by memory, including an accept this cycle, minus a response arriving now.
            drop_d = drop_q + DW'(q_pend) + DW'(req_acc) - DW'(imem_rsp_valid_i);
        end else begin
            if (req_acc) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - DW'(1);
            end
            cnt_d = DW'(q_count) + DW'(rsv_en) - DW'(pop_en);
        end
        // Outstanding discards also throttle issue so they stay bounded across back-to-back redirects.
        state_d = ((cnt_d < SLOTS) && ((cnt_d + drop_d) < LIMIT)) ? ST_REQ : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= INSTR_NOP;
            inst_pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (redirect_valid_i) begin
                inst_valid_q <= 1'b0;
            end else if (out_free) begin
                inst_valid_q <= q_head_ready;
                if (q_head_ready) begin
                    inst_q    <= q_head_instr;
                    inst_pc_q <= q_head_pc;
                end
            end
            assert (!(imem_rsp_valid_i && (drop_q == '0) && (q_pend == '0)));
            assert ((DW'(q_count) + drop_q) <= LIMIT);
        end
    end

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_valid_q ? inst_q : INSTR_NOP;
    assign inst_pc_o    = inst_valid_q ? inst_pc_q : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model and a PC/instruction scoreboard.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int acc_cnt = 0;
    int first_valid_cyc = -1;
    int mem_lat = 1;
    logic        mem_rdy = 1'b1;
    logic        dec_rdy = 1'b1;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic [31:0] last_acc_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hbeef, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // One clock: drive this cycle's inputs just after the edge, then record accepts and transfers.
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = 32'h0;
        end
        imem_req_ready_i = mem_rdy;
        inst_ready_i     = dec_rdy;
        redirect_valid_i = redir;
        redirect_pc_i    = redir_pc;
        if (first_valid_cyc < 0 && inst_valid_o) first_valid_cyc = cyc;
        if (imem_req_valid_o && imem_req_ready_i) begin
            mem_q.push_back('{addr: imem_req_addr_o, due: cyc + mem_lat});
            last_acc_addr = imem_req_addr_o;
            acc_cnt++;
        end
        if (inst_valid_o && inst_ready_i) begin
            xfer_cnt++;
            chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("xfer_pc", inst_pc_o, e);
                chk("xfer_instr", inst_o, mem_word(e));
            end
        end
    endtask

    task automatic wait_xfers(input string tag, input int n, input int budget);
        int target;
        target = xfer_cnt + n;
        for (int i = 0; i < budget && xfer_cnt < target; i++) tick();
        chk(tag, {31'd0, xfer_cnt >= target}, 32'd1);
    endtask

    task automatic wait_inflight2(input string tag);
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) tick();
        chk(tag, 32'(mem_q.size()), 32'd2);
    endtask

    initial begin
        int acc0;
        logic [31:0] hold_addr;

        rst_n = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = 32'h0;
        inst_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst_nop", inst_o, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        rst_n = 1'b1;
        cyc = 0;
        #1;
        chk("cyc0_req_valid", {31'd0, imem_req_valid_o}, 32'd0);

        // Straight-line streaming from the reset PC.
        expect_run(32'h0, 64);
        tick();
        chk("cyc1_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        chk("cyc1_req_addr", imem_req_addr_o, 32'h0);
        while (cyc < 10) tick();
        chk("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        chk("throughput_8_by_cyc10", 32'(xfer_cnt), 32'd8);

        // Decode stall: head holds, issue stops once slots run out.
        dec_rdy = 1'b0;
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_head_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("stall_head_pc", inst_pc_o, exp_q[0]);
        end
        chk("stall_req_off", {31'd0, imem_req_valid_o}, 32'd0);
        chk("stall_accepts_le_depth", {31'd0, (acc_cnt - acc0) <= DEPTH}, 32'd1);
        dec_rdy = 1'b1;
        repeat (4) tick();

        // Memory stall: address held and PC not advanced.
        mem_rdy = 1'b0;
        hold_addr = last_acc_addr + 32'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("memstall_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
            chk("memstall_addr_held", imem_req_addr_o, hold_addr);
        end
        mem_rdy = 1'b1;
        tick();
        chk("memstall_resume_valid", {31'd0, imem_req_valid_o}, 32'd1);
        chk("memstall_resume_addr", imem_req_addr_o, hold_addr);
        repeat (3) tick();

        // Redirect to 0x100 with two requests outstanding.
        mem_lat = 3;
        wait_inflight2("redir1_two_inflight");
        redir = 1'b1;
        redir_pc = 32'h100;
        tick();
        redir = 1'b0;
        mem_lat = 1;
        exp_q.delete();
        expect_run(32'h100, 64);
        tick();
        chk("redir1_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        chk("redir1_req_addr", imem_req_addr_o, 32'h100);
        wait_xfers("redir1_stream", 6, 40);

        // Redirect to 0x203 coinciding with a response and a head transfer.
        redir = 1'b1;
        redir_pc = 32'h203;
        tick();
        chk("redir2_rsp_same_cycle", {31'd0, imem_rsp_valid_i}, 32'd1);
        chk("redir2_xfer_same_cycle", {31'd0, inst_valid_o && inst_ready_i}, 32'd1);
        redir = 1'b0;
        exp_q.delete();
        expect_run(32'h200, 64);
        tick();
        chk("redir2_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        chk("redir2_req_addr", imem_req_addr_o, 32'h200);
        wait_xfers("redir2_stream", 6, 40);

        // Reset mid-stream with two requests outstanding; memory model restarts empty.
        mem_lat = 3;
        wait_inflight2("rst2_two_inflight");
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
        chk("rst2_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst2_inst_nop", inst_o, 32'h0000_0013);
        chk("rst2_inst_pc", inst_pc_o, 32'h0);
        mem_q.delete();
        exp_q.delete();
        imem_rsp_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        mem_lat = 1;
        expect_run(32'h0, 64);
        tick();
        chk("rst2_cyc1_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        chk("rst2_cyc1_req_addr", imem_req_addr_o, 32'h0);
        wait_xfers("rst2_stream", 6, 40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
